// File: rtl/m6502_bus_responder_if.sv
// CPU-side memory bus between m6502_cpu (master) and m6502_bus_responder (slave).
// rd_count/wr_count exist only when M6502_BUS_STATS_EN is defined.
interface m6502_bus_responder_if;
    logic [15:0] addr;
    logic        rd_req;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        ready;
    logic        err;
    logic        err_clr;
`ifdef M6502_BUS_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    modport master (
        output addr, rd_req, wr_en, wr_data, err_clr,
        input  rd_data, ready, err
`ifdef M6502_BUS_STATS_EN
        , input rd_count, wr_count
`endif
    );

    modport slave (
        input  addr, rd_req, wr_en, wr_data, err_clr,
        output rd_data, ready, err
`ifdef M6502_BUS_STATS_EN
        , output rd_count, wr_count
`endif
    );
endinterface

// File: rtl/m6502_bus_responder.sv
// m6502 bus target: byte RAM from 16'h0000 upward plus vector ROM at FFFA..FFFF, with optional wait states.
// Define M6502_BUS_STATS_EN to add saturating rd_count/wr_count outputs.
module m6502_bus_responder #(
    parameter int          ADDR_BITS    = 14,
    parameter int          WAIT_STATES  = 0,
    parameter logic [15:0] NMI_VECTOR   = 16'h0000,
    parameter logic [15:0] RESET_VECTOR = 16'h0200,
    parameter logic [15:0] IRQ_VECTOR   = 16'h0000
) (
    input logic                  clk,
    input logic                  reset,
    m6502_bus_responder_if.slave bus
);
    localparam int          DATA_W    = 8;
    localparam int          RAM_BYTES = 1 << ADDR_BITS;
    localparam logic [16:0] RAM_TOP   = 17'(RAM_BYTES);
    localparam bit          NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
    typedef enum logic [1:0] {REG_RAM, REG_ROM, REG_NONE} region_t;

    function automatic region_t decode(input logic [15:0] a);
        if ({1'b0, a} < RAM_TOP) return REG_RAM;
        if (a >= 16'hFFFA) return REG_ROM;
        return REG_NONE;
    endfunction

    function automatic logic [DATA_W-1:0] rom_byte(input logic [2:0] off);
        case (off)
            3'd2:    return NMI_VECTOR[7:0];
            3'd3:    return NMI_VECTOR[15:8];
            3'd4:    return RESET_VECTOR[7:0];
            3'd5:    return RESET_VECTOR[15:8];
            3'd6:    return IRQ_VECTOR[7:0];
            3'd7:    return IRQ_VECTOR[15:8];
            default: return 8'hFF;
        endcase
    endfunction

    state_t            state;
    logic [3:0]        cnt;
    logic              ready_r;
    logic              err_r;
    logic [DATA_W-1:0] rd_data_r;

    logic [15:0]       addr_p1;
    logic [DATA_W-1:0] wr_data_p1;
    logic              is_wr_p1;

    logic [DATA_W-1:0] mem [RAM_BYTES];

    logic              req;
    logic              accept;
    logic              stall_req;
    logic              collide;
    logic              go_now;
    logic              go_late;
    logic              do_acc;
    logic              acc_wr;
    logic [15:0]       acc_addr;
    logic [DATA_W-1:0] acc_data;
    region_t           acc_region;
    logic              set_err;

    // With no wait states the access uses the live bus; otherwise it uses the captured request.
    always_comb begin
        req        = bus.rd_req | bus.wr_en;
        accept     = req & (state != WAIT);
        stall_req  = req & (state == WAIT);
        collide    = bus.rd_req & bus.wr_en;
        go_now     = accept & NO_WAIT;
        go_late    = (state == WAIT) & (cnt == 4'd1);
        do_acc     = ~reset & (go_now | go_late);
        acc_addr   = go_late ? addr_p1    : bus.addr;
        acc_data   = go_late ? wr_data_p1 : bus.wr_data;
        acc_wr     = go_late ? is_wr_p1   : bus.wr_en;
        acc_region = decode(acc_addr);
        set_err    = stall_req
                   | (accept & collide)
                   | (do_acc & (acc_region == REG_NONE))
                   | (do_acc & acc_wr & (acc_region == REG_ROM));
    end

    // Request capture stage (p1)
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1    <= bus.addr;
            wr_data_p1 <= bus.wr_data;
            is_wr_p1   <= bus.wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (do_acc && acc_wr && (acc_region == REG_RAM))
            mem[acc_addr[ADDR_BITS-1:0]] <= acc_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ready_r   <= 1'b1;
            rd_data_r <= '0;
            err_r     <= 1'b0;
            cnt       <= '0;
        end else begin
            if (set_err)          err_r <= 1'b1;
            else if (bus.err_clr) err_r <= 1'b0;

            if (do_acc && !acc_wr) begin
                case (acc_region)
                    REG_RAM: rd_data_r <= mem[acc_addr[ADDR_BITS-1:0]];
                    REG_ROM: rd_data_r <= rom_byte(acc_addr[2:0]);
                    default: rd_data_r <= 8'hFF;
                endcase
            end

            // ACCESS has ready=1, so it accepts a new request exactly like IDLE.
            case (state)
                IDLE, ACCESS: begin
                    if (accept && !NO_WAIT) begin
                        state   <= WAIT;
                        ready_r <= 1'b0;
                        cnt     <= WAIT_INIT;
                    end else begin
                        state   <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state   <= ACCESS;
                        ready_r <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt     <= cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready   = ready_r;
    assign bus.rd_data = rd_data_r;
    assign bus.err     = err_r;

`ifdef M6502_BUS_STATS_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    always_ff @(posedge clk) begin
        if (reset || bus.err_clr) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (do_acc && !acc_wr && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 16'd1;
            if (do_acc &&  acc_wr && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
        end
    end

    assign bus.rd_count = rd_cnt;
    assign bus.wr_count = wr_cnt;
`endif
endmodule

// File: tb/tb_m6502_bus_responder.sv
// Scoreboard bench: d0 has no wait states, d3 has three; per-DUT monitors pop expectations on completion.
module tb_m6502_bus_responder;
    typedef struct {
        string      name;
        logic [7:0] data;
        logic       err;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst0;
    logic rst3;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q3[$];
    bit   pend0 = 0;
    bit   pend3 = 0;
    int   lat0 = 0;
    int   lat3 = 0;
    int   drops0 = 0;

    always #5 clk = ~clk;

    m6502_bus_responder_if b0();
    m6502_bus_responder_if b3();

    m6502_bus_responder #(.WAIT_STATES(0), .NMI_VECTOR(16'h1234), .IRQ_VECTOR(16'h5678))
        d0 (.clk(clk), .reset(rst0), .bus(b0));
    m6502_bus_responder #(.WAIT_STATES(3))
        d3 (.clk(clk), .reset(rst3), .bus(b3));

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic score(input string who, input exp_t e, input logic [7:0] d, input logic er, input int lat);
        chk({who, " ", e.name, " rd_data"}, {8'h00, d}, {8'h00, e.data});
        chk({who, " ", e.name, " err"}, {15'h0, er}, {15'h0, e.err});
        chk({who, " ", e.name, " stall cycles"}, 16'(lat), 16'(e.lat));
    endtask

    task automatic expect0(input string name, input logic [7:0] d, input logic er);
        exp_t e;
        e.name = name; e.data = d; e.err = er; e.lat = 0;
        q0.push_back(e);
    endtask

    task automatic expect3(input string name, input logic [7:0] d, input logic er);
        exp_t e;
        e.name = name; e.data = d; e.err = er; e.lat = 3;
        q3.push_back(e);
    endtask

    task automatic issue0(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d, input bit clr);
        b0.rd_req = rd; b0.wr_en = wr; b0.addr = a; b0.wr_data = d; b0.err_clr = clr;
        @(posedge clk); #1;
        b0.rd_req = 1'b0; b0.wr_en = 1'b0; b0.err_clr = 1'b0;
    endtask

    task automatic issue3(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d, input bit clr);
        b3.rd_req = rd; b3.wr_en = wr; b3.addr = a; b3.wr_data = d; b3.err_clr = clr;
        @(posedge clk); #1;
        b3.rd_req = 1'b0; b3.wr_en = 1'b0; b3.err_clr = 1'b0;
    endtask

    task automatic wait_ready3(input string name);
        int n = 0;
        while (b3.ready !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk({"d3 ", name, " ready returns"}, {15'h0, b3.ready}, 16'h0001);
    endtask

    // Monitors: a request accepted while ready=1 completes at the first negedge where ready=1 again.
    always @(posedge clk) begin
        if (rst0) pend0 = 0;
        else if ((b0.rd_req || b0.wr_en) && b0.ready === 1'b1) begin pend0 = 1; lat0 = 0; end
        if (rst3) pend3 = 0;
        else if ((b3.rd_req || b3.wr_en) && b3.ready === 1'b1) begin pend3 = 1; lat3 = 0; end
    end

    always @(negedge clk) begin
        if (!rst0 && b0.ready !== 1'b1) drops0++;
        if (pend0) begin
            if (b0.ready === 1'b1) begin
                pend0 = 0;
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d0 unexpected completion rd_data %h expected none", b0.rd_data);
                end else score("d0", q0.pop_front(), b0.rd_data, b0.err, lat0);
            end else if (++lat0 > 20) begin
                pend0 = 0; checks++; errors++;
                $display("FAIL d0 completion timeout ready %b expected 1", b0.ready);
            end
        end
        if (pend3) begin
            if (b3.ready === 1'b1) begin
                pend3 = 0;
                if (q3.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d3 unexpected completion rd_data %h expected none", b3.rd_data);
                end else score("d3", q3.pop_front(), b3.rd_data, b3.err, lat3);
            end else if (++lat3 > 20) begin
                pend3 = 0; checks++; errors++;
                $display("FAIL d3 completion timeout ready %b expected 1", b3.ready);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; rst3 = 1'b1;
        b0.rd_req = 0; b0.wr_en = 0; b0.addr = '0; b0.wr_data = '0; b0.err_clr = 0;
        b3.rd_req = 0; b3.wr_en = 0; b3.addr = '0; b3.wr_data = '0; b3.err_clr = 0;
        repeat (2) @(posedge clk);
        #1; rst0 = 1'b0; rst3 = 1'b0;

        chk("d0 reset ready", {15'h0, b0.ready}, 16'h0001);
        chk("d0 reset rd_data", {8'h0, b0.rd_data}, 16'h0000);
        chk("d0 reset err", {15'h0, b0.err}, 16'h0000);
        chk("d3 reset ready", {15'h0, b3.ready}, 16'h0001);
        chk("d3 reset rd_data", {8'h0, b3.rd_data}, 16'h0000);
        chk("d3 reset err", {15'h0, b3.err}, 16'h0000);

        // ---- d0: zero wait states, back-to-back every cycle ----
        expect0("rd FFFC", 8'h00, 1'b0); issue0(1, 0, 16'hFFFC, 8'h00, 0);
        expect0("rd FFFD", 8'h02, 1'b0); issue0(1, 0, 16'hFFFD, 8'h00, 0);
        expect0("wr 0010", 8'h02, 1'b0); issue0(0, 1, 16'h0010, 8'hA5, 0);
        expect0("rd 0010", 8'hA5, 1'b0); issue0(1, 0, 16'h0010, 8'h00, 0);
        expect0("wr 3FFF", 8'hA5, 1'b0); issue0(0, 1, 16'h3FFF, 8'h7E, 0);
        expect0("rd 3FFF", 8'h7E, 1'b0); issue0(1, 0, 16'h3FFF, 8'h00, 0);
        expect0("rd FFFA", 8'h34, 1'b0); issue0(1, 0, 16'hFFFA, 8'h00, 0);
        expect0("rd FFFB", 8'h12, 1'b0); issue0(1, 0, 16'hFFFB, 8'h00, 0);
        expect0("rd FFFE", 8'h78, 1'b0); issue0(1, 0, 16'hFFFE, 8'h00, 0);
        expect0("rd FFFF", 8'h56, 1'b0); issue0(1, 0, 16'hFFFF, 8'h00, 0);
        expect0("rd 4000", 8'hFF, 1'b1); issue0(1, 0, 16'h4000, 8'h00, 0);
        issue0(0, 0, 16'h0000, 8'h00, 1);
        chk("d0 err_clr after 4000", {15'h0, b0.err}, 16'h0000);
        expect0("wr FFFC", 8'hFF, 1'b1); issue0(0, 1, 16'hFFFC, 8'h55, 0);
        expect0("rd FFFC after wr", 8'h00, 1'b1); issue0(1, 0, 16'hFFFC, 8'h00, 0);
        issue0(0, 0, 16'h0000, 8'h00, 1);
        chk("d0 err_clr after rom wr", {15'h0, b0.err}, 16'h0000);
        expect0("rd FFF9 with clr", 8'hFF, 1'b1); issue0(1, 0, 16'hFFF9, 8'h00, 1);
        issue0(0, 0, 16'h0000, 8'h00, 1);
        chk("d0 err_clr after FFF9", {15'h0, b0.err}, 16'h0000);
        expect0("rd+wr 0020", 8'hFF, 1'b1); issue0(1, 1, 16'h0020, 8'h3C, 0);
        issue0(0, 0, 16'h0000, 8'h00, 1);
        expect0("rd 0020", 8'h3C, 1'b0); issue0(1, 0, 16'h0020, 8'h00, 0);
        expect0("rd 8000", 8'hFF, 1'b1); issue0(1, 0, 16'h8000, 8'h00, 0);
        issue0(0, 0, 16'h0000, 8'h00, 1);
        chk("d0 err_clr after 8000", {15'h0, b0.err}, 16'h0000);
`ifdef M6502_BUS_STATS_EN
        chk("d0 rd_count cleared", b0.rd_count, 16'h0000);
        expect0("st rd 0010", 8'hA5, 1'b0); issue0(1, 0, 16'h0010, 8'h00, 0);
        expect0("st rd 0020", 8'h3C, 1'b0); issue0(1, 0, 16'h0020, 8'h00, 0);
        expect0("st rd FFFC", 8'h00, 1'b0); issue0(1, 0, 16'hFFFC, 8'h00, 0);
        expect0("st rd FFFD", 8'h02, 1'b0); issue0(1, 0, 16'hFFFD, 8'h00, 0);
        expect0("st rd 3FFF", 8'h7E, 1'b0); issue0(1, 0, 16'h3FFF, 8'h00, 0);
        expect0("st wr 0040", 8'h7E, 1'b0); issue0(0, 1, 16'h0040, 8'h01, 0);
        expect0("st wr FFFE", 8'h7E, 1'b1); issue0(0, 1, 16'hFFFE, 8'h02, 0);
        chk("d0 rd_count", b0.rd_count, 16'd5);
        chk("d0 wr_count", b0.wr_count, 16'd2);
`endif

        // ---- d3: three wait states ----
        expect3("wr 0010", 8'h00, 1'b0); issue3(0, 1, 16'h0010, 8'hA5, 0);
        wait_ready3("wr 0010");
        expect3("rd 0010 stalled rd", 8'hA5, 1'b1); issue3(1, 0, 16'h0010, 8'h00, 0);
        issue3(1, 0, 16'h0000, 8'h00, 0);
        wait_ready3("rd 0010");
        issue3(0, 0, 16'h0000, 8'h00, 1);
        chk("d3 err_clr", {15'h0, b3.err}, 16'h0000);
        expect3("wr 0030", 8'hA5, 1'b0); issue3(0, 1, 16'h0030, 8'h11, 0);
        wait_ready3("wr 0030");
        issue3(0, 1, 16'h0030, 8'h77, 0);
        chk("d3 ready low in wait", {15'h0, b3.ready}, 16'h0000);
        repeat (2) begin @(posedge clk); #1; end
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        chk("d3 ready after abort", {15'h0, b3.ready}, 16'h0001);
        chk("d3 rd_data after abort", {8'h0, b3.rd_data}, 16'h0000);
        chk("d3 err after abort", {15'h0, b3.err}, 16'h0000);
        expect3("rd 0030 after abort", 8'h11, 1'b0); issue3(1, 0, 16'h0030, 8'h00, 0);
        wait_ready3("rd 0030");
        expect3("rd 4000", 8'hFF, 1'b1); issue3(1, 0, 16'h4000, 8'h00, 0);
        wait_ready3("rd 4000");

        repeat (3) begin @(posedge clk); #1; end
        chk("d0 ready drops", 16'(drops0), 16'h0000);
        chk("d0 queue drained", 16'(q0.size()), 16'h0000);
        chk("d3 queue drained", 16'(q3.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
